// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its writeback arbiter.
// Address width, the hardwired-zero register and the arbiter state encoding live here.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_SAT = {STARVE_W{1'b1}};

  typedef enum logic {
    A_PRI = 1'b0,
    B_PRI = 1'b1
  } wb_state_t;

  // Register 0 is hardwired to zero, so a transfer there never raises the write strobe.
  function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_starve_counter.sv
// Counts consecutive cycles in which requester B waits while A is granted.
// Raises starve_hit on the cycle the count reaches STARVE_MAX so priority flips next cycle.
module wb_starve_counter
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b_valid,
  input  logic a_grant,
  input  logic b_grant,
  output logic starve_hit
);

  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] count_reg;
  logic [STARVE_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (b_grant || !b_valid) begin
      count_next = '0;
    end else if (a_grant && (count_reg != STARVE_SAT)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Compare against the next value so B wins on the cycle right after its last loss.
  assign starve_hit = (count_next >= STARVE_LIMIT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regFile write port between the ALU (A) and load/multiply (B) writebacks.
// A has priority, B is protected against starvation, and same-register conflicts favour B.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N          = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  A_Valid_i,
  output logic                  A_Ready_o,
  input  logic [REG_ADDR_W-1:0] A_Register_i,
  input  logic [N-1:0]          A_Data_i,
  input  logic                  B_Valid_i,
  output logic                  B_Ready_o,
  input  logic [REG_ADDR_W-1:0] B_Register_i,
  input  logic [N-1:0]          B_Data_i,
  output logic                  Reg_Write_o,
  output logic [REG_ADDR_W-1:0] Write_Register_o,
  output logic [N-1:0]          Write_Data_o,
  output logic                  Starved_o
);

  wb_state_t state_reg;
  wb_state_t state_next;

  logic                  collision;
  logic                  grant_a;
  logic                  grant_b;
  logic                  starve_hit;
  logic [REG_ADDR_W-1:0] sel_register;
  logic [N-1:0]          sel_data;

  logic                  reg_write_reg;
  logic [REG_ADDR_W-1:0] write_register_reg;
  logic [N-1:0]          write_data_reg;
  logic                  starved_reg;

  // B holds the older result for a shared destination, so it must land first.
  assign collision = A_Valid_i && B_Valid_i &&
                     (A_Register_i == B_Register_i) && is_writable(A_Register_i);

  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = state_reg;
    if (reset) begin
      if (collision) begin
        grant_b = 1'b1;
      end else if (state_reg == B_PRI) begin
        if (B_Valid_i) begin
          grant_b = 1'b1;
        end else if (A_Valid_i) begin
          grant_a = 1'b1;
        end
      end else begin
        if (A_Valid_i) begin
          grant_a = 1'b1;
        end else if (B_Valid_i) begin
          grant_b = 1'b1;
        end
      end

      if (state_reg == A_PRI) begin
        if (starve_hit) begin
          state_next = B_PRI;
        end
      end else begin
        if (grant_b || !B_Valid_i) begin
          state_next = A_PRI;
        end
      end
    end
  end

  always_comb begin
    sel_register = A_Register_i;
    sel_data     = A_Data_i;
    if (grant_b) begin
      sel_register = B_Register_i;
      sel_data     = B_Data_i;
    end
  end

  wb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk        (clk),
    .rst_n      (reset),
    .b_valid    (B_Valid_i),
    .a_grant    (grant_a),
    .b_grant    (grant_b),
    .starve_hit (starve_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg          <= A_PRI;
      starved_reg        <= 1'b0;
      reg_write_reg      <= 1'b0;
      write_register_reg <= ZERO_REG;
      write_data_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      starved_reg <= (state_next == B_PRI);
      if (grant_a || grant_b) begin
        reg_write_reg      <= is_writable(sel_register);
        write_register_reg <= sel_register;
        write_data_reg     <= sel_data;
      end else begin
        reg_write_reg <= 1'b0;
      end
    end
  end

  assign A_Ready_o        = grant_a;
  assign B_Ready_o        = grant_b;
  assign Reg_Write_o      = reg_write_reg;
  assign Write_Register_o = write_register_reg;
  assign Write_Data_o     = write_data_reg;
  assign Starved_o        = starved_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a behavioural reference model.
// A bench-side register file absorbs the DUT write port to observe committed values.
module tb_regfile_wb_arbiter;

  localparam int N          = 32;
  localparam int STARVE_MAX = 3;

  logic         clk = 1'b1;
  logic         reset;
  logic         A_Valid_i;
  logic         A_Ready_o;
  logic [4:0]   A_Register_i;
  logic [N-1:0] A_Data_i;
  logic         B_Valid_i;
  logic         B_Ready_o;
  logic [4:0]   B_Register_i;
  logic [N-1:0] B_Data_i;
  logic         Reg_Write_o;
  logic [4:0]   Write_Register_o;
  logic [N-1:0] Write_Data_o;
  logic         Starved_o;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .N          (N),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .A_Valid_i        (A_Valid_i),
    .A_Ready_o        (A_Ready_o),
    .A_Register_i     (A_Register_i),
    .A_Data_i         (A_Data_i),
    .B_Valid_i        (B_Valid_i),
    .B_Ready_o        (B_Ready_o),
    .B_Register_i     (B_Register_i),
    .B_Data_i         (B_Data_i),
    .Reg_Write_o      (Reg_Write_o),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o),
    .Starved_o        (Starved_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: how many times in a row B has lost, and whether B currently has priority.
  int           m_losses;
  bit           m_bpri;
  logic         exp_rw;
  logic [4:0]   exp_reg;
  logic [N-1:0] exp_data;
  bit           m_pend;
  logic [4:0]   m_pend_reg;
  logic [N-1:0] m_pend_data;
  logic [N-1:0] exp_rf [32];
  logic [N-1:0] obs_rf [32];
  bit           g_a;
  bit           g_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_losses = 0;
    m_bpri   = 1'b0;
    exp_rw   = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
    m_pend   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_reg_write"}, Reg_Write_o, exp_rw);
    check({tag, "_write_reg"}, Write_Register_o, exp_reg);
    check({tag, "_write_data"}, Write_Data_o, exp_data);
    check({tag, "_starved"}, Starved_o, m_bpri);
  endtask

  // One clock cycle: predict and check readies, advance across the edge, check registered outputs.
  task automatic do_cycle();
    bit           ga;
    bit           gb;
    bit           same_dest;
    bit           b_waiting;
    logic [4:0]   r;
    logic [N-1:0] d;
    logic         dut_rw;
    logic [4:0]   dut_reg;
    logic [N-1:0] dut_data;
    #1;
    same_dest = A_Valid_i && B_Valid_i && (A_Register_i == B_Register_i) && (A_Register_i != 5'd0);
    ga = 1'b0;
    gb = 1'b0;
    if (reset) begin
      if (same_dest) gb = 1'b1;
      else if (m_bpri) begin
        if (B_Valid_i) gb = 1'b1;
        else if (A_Valid_i) ga = 1'b1;
      end else begin
        if (A_Valid_i) ga = 1'b1;
        else if (B_Valid_i) gb = 1'b1;
      end
    end
    check("a_ready", A_Ready_o, ga);
    check("b_ready", B_Ready_o, gb);
    r         = ga ? A_Register_i : B_Register_i;
    d         = ga ? A_Data_i : B_Data_i;
    b_waiting = B_Valid_i;
    dut_rw    = Reg_Write_o;
    dut_reg   = Write_Register_o;
    dut_data  = Write_Data_o;
    @(posedge clk);
    #1;
    if (dut_rw) obs_rf[dut_reg] = dut_data;
    if (m_pend) exp_rf[m_pend_reg] = m_pend_data;
    if (ga || gb) begin
      exp_reg  = r;
      exp_data = d;
      exp_rw   = (r != 5'd0);
      $display("txn t=%0t grant=%s reg=%0d data=%08h", $time, ga ? "A" : "B", r, d);
    end else begin
      exp_rw = 1'b0;
    end
    if (b_waiting && ga) m_losses = (m_losses < 15) ? m_losses + 1 : 15;
    else m_losses = 0;
    m_bpri      = (m_losses >= STARVE_MAX);
    m_pend      = (ga || gb) && (r != 5'd0);
    m_pend_reg  = r;
    m_pend_data = d;
    check_outputs("cycle");
    g_a = ga;
    g_b = gb;
  endtask

  // A streams writes from a_start upward while B waits; returns how many A grants preceded B's.
  task automatic run_starve(input logic [4:0] a_start, output int a_wins);
    a_wins = 0;
    A_Valid_i    = 1'b1;
    A_Register_i = a_start;
    A_Data_i     = $urandom;
    for (int i = 0; i < 12; i++) begin
      do_cycle();
      if (g_b) break;
      if (g_a) begin
        a_wins++;
        A_Register_i = A_Register_i + 5'd1;
        A_Data_i     = $urandom;
      end
    end
    B_Valid_i = 1'b0;
  endtask

  initial begin
    int a_wins;

    for (int i = 0; i < 32; i++) begin
      exp_rf[i] = '0;
      obs_rf[i] = '0;
    end
    model_reset();

    // Reset with A already requesting: readies forced low, outputs at reset values.
    reset        = 1'b0;
    A_Valid_i    = 1'b1;
    A_Register_i = 5'd1;
    A_Data_i     = 32'd3;
    B_Valid_i    = 1'b0;
    B_Register_i = 5'd0;
    B_Data_i     = '0;
    #4;
    check("rst_a_ready", A_Ready_o, 1'b0);
    check("rst_b_ready", B_Ready_o, 1'b0);
    check_outputs("rst");
    #1;
    reset = 1'b1;

    // Single A write to reg 1.
    do_cycle();
    check("first_grant_a", g_a, 1'b1);
    check("first_reg_write", Reg_Write_o, 1'b1);
    A_Valid_i = 1'b0;

    // Starvation guard: A wins STARVE_MAX times, then B lands reg 20.
    B_Valid_i    = 1'b1;
    B_Register_i = 5'd20;
    B_Data_i     = 32'd256;
    run_starve(5'd2, a_wins);
    check("a_wins_before_b", a_wins, STARVE_MAX);
    do_cycle();
    check("starved_cleared", Starved_o, 1'b0);
    A_Valid_i = 1'b0;
    do_cycle();
    check("rf20", obs_rf[20], 32'd256);

    // Same destination: B's older value lands first, A's overwrites it.
    A_Valid_i    = 1'b1;
    A_Register_i = 5'd7;
    A_Data_i     = 32'h11;
    B_Valid_i    = 1'b1;
    B_Register_i = 5'd7;
    B_Data_i     = 32'h22;
    do_cycle();
    check("collision_b_first", g_b, 1'b1);
    B_Valid_i = 1'b0;
    do_cycle();
    A_Valid_i = 1'b0;
    check("rf7_first", obs_rf[7], 32'h22);
    do_cycle();
    check("rf7_final", obs_rf[7], 32'h11);

    // Register 0: handshake completes, no write strobe.
    A_Valid_i    = 1'b1;
    A_Register_i = 5'd0;
    A_Data_i     = 32'd20;
    do_cycle();
    A_Valid_i = 1'b0;
    do_cycle();
    check("rf0", obs_rf[0], 32'd0);

    // Reset right after a grant: transfer dropped, counter and state cleared.
    A_Valid_i    = 1'b1;
    A_Register_i = 5'd9;
    A_Data_i     = 32'h99;
    B_Valid_i    = 1'b1;
    B_Register_i = 5'd30;
    B_Data_i     = 32'h30;
    do_cycle();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("midrst");
    #2;
    reset = 1'b1;
    run_starve(5'd10, a_wins);
    check("a_wins_after_reset", a_wins, STARVE_MAX);
    A_Valid_i = 1'b0;
    do_cycle();
    check("rf9_dropped", obs_rf[9], 32'd0);
    check("rf30", obs_rf[30], 32'h30);

    // Idle: nothing granted, last register and data held.
    for (int i = 0; i < 10; i++) do_cycle();

    // Randomized traffic with small register range to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      do_cycle();
      if (g_a) A_Valid_i = 1'b0;
      if (g_b) B_Valid_i = 1'b0;
      else if (B_Valid_i && ($urandom_range(0, 15) == 0)) B_Valid_i = 1'b0;
      if (!A_Valid_i && ($urandom_range(0, 3) != 0)) begin
        A_Valid_i    = 1'b1;
        A_Register_i = 5'($urandom_range(0, 7));
        A_Data_i     = $urandom;
      end
      if (!B_Valid_i && ($urandom_range(0, 2) == 0)) begin
        B_Valid_i    = 1'b1;
        B_Register_i = 5'($urandom_range(0, 7));
        B_Data_i     = $urandom;
      end
    end
    A_Valid_i = 1'b0;
    B_Valid_i = 1'b0;
    do_cycle();
    do_cycle();
    for (int i = 0; i < 8; i++) check($sformatf("rf_final_%0d", i), obs_rf[i], exp_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32×N register file (`regFile`). It shares the register file's single write port between two writeback requesters. Requester A is the primary ALU writeback path; requester B is the long-latency load/multiply writeback path. The block uses valid/ready handshakes, A-priority arbitration with a starvation guard for B, and registered outputs that drive `regFile` write controls directly.

## Interface
- `N`, 32, data width; matches `regFile` `N`.
- `STARVE_MAX`, 3, consecutive B-losing cycles before B is forced to win; legal range 1–15.
- `clk`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `A_Valid_i`  in  1  A has a writeback pending.
- `A_Ready_o`  out  1  A is granted this cycle.
- `A_Register_i`  in  5  A destination register.
- `A_Data_i`  in  N  A write data.
- `B_Valid_i`  in  1  B has a writeback pending.
- `B_Ready_o`  out  1  B is granted this cycle.
- `B_Register_i`  in  5  B destination register.
- `B_Data_i`  in  N  B write data.
- `Reg_Write_o`  out  1  to `regFile` `Reg_Write_i`.
- `Write_Register_o`  out  5  to `regFile` `Write_Register_i`.
- `Write_Data_o`  out  N  to `regFile` `Write_Data_i`.
- `Starved_o`  out  1  high while the FSM is in `B_PRI`.

## Operation
- A transfer occurs on an edge where `X_Valid_i && X_Ready_o`. At most one grant per cycle.
- Ready signals are combinational from valids and FSM state, never from data. Exactly one ready is high when any valid is high; both are low when neither valid is high.
- FSM states:
  - `A_PRI` (reset state): grant A if `A_Valid_i`, else grant B if `B_Valid_i`.
  - `B_PRI`: grant B if `B_Valid_i`, else A.
- Starvation counter (4 bits):
  - Increments on each cycle where B is valid and A is granted.
  - Clears on any B grant, and on any cycle B is not valid.
  - When the counter reaches `STARVE_MAX`, the FSM goes `A_PRI` → `B_PRI` next cycle.
  - `B_PRI` → `A_PRI` after one B grant, or if `B_Valid_i` drops.
- Same-register collision: both valid with `A_Register_i == B_Register_i != 0` → B is granted regardless of state (B holds the older result), and A is granted on a following cycle. This forced grant does not increment the counter.
- Register 0: a granted transfer with destination 0 completes the handshake. `Reg_Write_o` stays 0 for it. Register and data outputs still update.
- Output register:
  - On a grant to a nonzero register, next cycle: `Reg_Write_o`=1, `Write_Register_o`/`Write_Data_o` = granted fields.
  - On no grant, `Reg_Write_o`=0 and register/data hold their last value.
- Arithmetic: counter saturates at 15 and never wraps.

## Timing
- Reset values: `Reg_Write_o`=0, `Write_Register_o`=0, `Write_Data_o`=0, `Starved_o`=0, counter=0, state=`A_PRI`.
- `A_Ready_o`/`B_Ready_o` are forced to 0 while `reset` is low.
- Latency: grant edge to `Reg_Write_o` high is 1 cycle. `regFile` commits on the following edge. Sustained throughput is 1 write per cycle.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). A transfer accepted on the preceding edge is dropped and never written.
- Requesters must hold valid, register, and data stable until granted. Valid must not drop before its grant; dropping B valid is tolerated and resets starvation state.
- `Starved_o` is registered and equals (state == `B_PRI`).

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W`=5 and `ZERO_REG`=5'd0, shared with `regFile`.
  - `wb_state_t` enum {`A_PRI`, `B_PRI`}.
  - `STARVE_W`=4.
- One sub-module: `wb_starve_counter`, holding the saturating counter, clear/increment logic, and the `STARVE_MAX` compare. The arbitration FSM, collision compare, and output register stay in the top module.

## Test plan
- Reset held low 5 ns, then released; only A valid, reg 1, data 3 → `A_Ready_o`=1; next cycle `Reg_Write_o`=1, `Write_Register_o`=1, `Write_Data_o`=3.
- A continuously valid (regs 2,3,4,…), B valid on reg 20 with data 256, `STARVE_MAX`=3 → A wins 3 cycles, `Starved_o` rises, B granted on the 4th cycle, reg 20 is written with 256, then the FSM returns to `A_PRI`.
- A and B both target reg 7 (A data 0x11, B data 0x22) → B is written first, then A; final reg 7 readback = 0x11.
- A writes reg 0 with data 20 → handshake completes, `Reg_Write_o` stays 0, `regFile` reg 0 reads 0.
- Grant on edge N, `reset` pulled low before edge N+1 → `Reg_Write_o`=0 immediately; register is not written; after release, the state is `A_PRI` and the counter is 0.
- Neither valid for 10 cycles → both readies 0, `Reg_Write_o`=0, outputs hold the last register and data values.
